// File: rtl/spmmio_keyboard_sched.sv
// Two-source key-event scheduler feeding the MMIO keyboard FIFO (round-robin, FIFO-full and gap aware).
// Define KBD_TYPEMATIC_EN to add typematic auto-repeat for source 0.
module spmmio_keyboard_sched #(
  parameter int               GAP_CYCLES   = 4,
  parameter int               CNT_W        = 24,
  parameter logic [CNT_W-1:0] REPEAT_DELAY = CNT_W'(500000),
  parameter logic [CNT_W-1:0] REPEAT_RATE  = CNT_W'(100000)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s0_valid,
  input  logic [6:0] s0_keycode,
  input  logic [3:0] s0_shift,
  input  logic       s0_held,
  output logic       s0_ack,
  input  logic       s1_valid,
  input  logic [6:0] s1_keycode,
  input  logic [3:0] s1_shift,
  output logic       s1_ack,
  input  logic       keyboard_block,
  input  logic       fifo_full,
  output logic       keypress,
  output logic [6:0] keycode,
  output logic [3:0] shift_state,
  output logic       last_src
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

  // ISSUE plus HOLDOFF plus the sampling IDLE cycle span GAP_CYCLES+1 cycles between strobes.
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 1) ? CNT_W'(GAP_CYCLES - 2) : '0;

  state_t           state, state_next;
  logic [CNT_W-1:0] gap_cnt;
  logic             rr;
  logic             elig0, elig1, take, pick1;
  logic             rep_pend, grant_rep;
  logic [6:0]       s0_code_sel;
  logic [3:0]       s0_shift_sel;

`ifdef KBD_TYPEMATIC_EN
  logic             rep_armed;
  logic [CNT_W-1:0] rep_cnt;
  logic [6:0]       rep_code;
  logic [3:0]       rep_shift;

  assign elig0        = (s0_valid | rep_pend) & ~keyboard_block;
  assign s0_code_sel  = s0_valid ? s0_keycode : rep_code;
  assign s0_shift_sel = s0_valid ? s0_shift   : rep_shift;

  // A fresh src0 event always re-arms; the counter only runs while the key stays down and unblocked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_armed <= 1'b0;
      rep_cnt   <= '0;
      rep_pend  <= 1'b0;
      rep_code  <= '0;
      rep_shift <= '0;
      grant_rep <= 1'b0;
    end else begin
      if (take) grant_rep <= ~pick1 & ~s0_valid;
      if (take & ~pick1 & s0_valid) begin
        rep_armed <= 1'b1;
        rep_cnt   <= REPEAT_DELAY - 1'b1;
        rep_code  <= s0_keycode;
        rep_shift <= s0_shift;
        rep_pend  <= 1'b0;
      end else if (~s0_held | keyboard_block) begin
        rep_armed <= 1'b0;
        rep_pend  <= 1'b0;
      end else if (rep_armed) begin
        if (rep_cnt == '0) begin
          rep_pend <= 1'b1;
          rep_cnt  <= REPEAT_RATE - 1'b1;
        end else begin
          rep_cnt <= rep_cnt - 1'b1;
          if (take & ~pick1) rep_pend <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_typematic;

  assign elig0            = s0_valid & ~keyboard_block;
  assign s0_code_sel      = s0_keycode;
  assign s0_shift_sel     = s0_shift;
  assign rep_pend         = 1'b0;
  assign grant_rep        = 1'b0;
  assign unused_typematic = ^{s0_held, REPEAT_DELAY, REPEAT_RATE};
`endif

  assign elig1 = s1_valid;
  assign take  = (state == IDLE) & (elig0 | elig1) & ~fifo_full;
  assign pick1 = elig1 & (~elig0 | rr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (take) state_next = ISSUE;
      ISSUE:   state_next = (GAP_CYCLES > 1) ? HOLDOFF : IDLE;
      HOLDOFF: if (gap_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt     <= '0;
      rr          <= 1'b0;
      keycode     <= '0;
      shift_state <= '0;
      last_src    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (take) begin
        rr          <= ~pick1;
        last_src    <= pick1;
        keycode     <= pick1 ? s1_keycode : s0_code_sel;
        shift_state <= pick1 ? s1_shift   : s0_shift_sel;
      end
      if (state == ISSUE)
        gap_cnt <= GAP_LOAD;
      else if ((state == HOLDOFF) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Strobes decode straight from state, so an asynchronous reset drops them at once.
  always_comb begin
    keypress = (state == ISSUE);
    s0_ack   = keypress & ~last_src & ~grant_rep;
    s1_ack   = keypress & last_src;
  end

endmodule

// File: tb/tb_spmmio_keyboard_sched.sv
// Self-checking bench for spmmio_keyboard_sched: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_spmmio_keyboard_sched;

  localparam int GAP   = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s0_valid = 1'b0, s1_valid = 1'b0, s0_held = 1'b0;
  logic [6:0] s0_keycode = '0, s1_keycode = '0;
  logic [3:0] s0_shift = '0, s1_shift = '0;
  logic       keyboard_block = 1'b0, fifo_full = 1'b0;
  logic       s0_ack, s1_ack, keypress, last_src;
  logic [6:0] keycode;
  logic [3:0] shift_state;

  always #5 clk = ~clk;

  spmmio_keyboard_sched #(
    .GAP_CYCLES(GAP), .CNT_W(24), .REPEAT_DELAY(24'd10), .REPEAT_RATE(24'd4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_valid(s0_valid), .s0_keycode(s0_keycode), .s0_shift(s0_shift), .s0_held(s0_held), .s0_ack(s0_ack),
    .s1_valid(s1_valid), .s1_keycode(s1_keycode), .s1_shift(s1_shift), .s1_ack(s1_ack),
    .keyboard_block(keyboard_block), .fifo_full(fifo_full),
    .keypress(keypress), .keycode(keycode), .shift_state(shift_state), .last_src(last_src)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: events may only be sampled once 'quiet' edges have passed since a grant.
  int         quiet = 0;
  bit         rr = 0;
  bit         m_kp = 0, m_a0 = 0, m_a1 = 0, m_last = 0;
  logic [6:0] m_code = '0;
  logic [3:0] m_shift = '0;
  bit         was_a0 = 0, was_a1 = 0;
  bit         e0, e1, g0, g1, grep;
  bit         rep_armed = 0, rep_pend = 0;
  int         rep_cnt = 0;
  logic [6:0] rep_code = '0;
  logic [3:0] rep_shift = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quiet = 0; rr = 0;
      m_kp = 0; m_a0 = 0; m_a1 = 0; m_last = 0; m_code = '0; m_shift = '0;
      was_a0 = 0; was_a1 = 0;
      rep_armed = 0; rep_pend = 0; rep_cnt = 0; rep_code = '0; rep_shift = '0;
    end else begin
      was_a0 = m_a0; was_a1 = m_a1;
      m_kp = 0; m_a0 = 0; m_a1 = 0;
      e0 = (s0_valid || rep_pend) && !keyboard_block;
      e1 = s1_valid;
      g0 = 0; g1 = 0; grep = 0;
      if (quiet > 0) quiet--;
      else if ((e0 || e1) && !fifo_full) begin
        if (e0 && (!e1 || !rr)) g0 = 1; else g1 = 1;
        rr = g0;
        quiet = (GAP > 1) ? GAP : 1;
        m_kp = 1; m_last = g1;
        if (g1) begin
          m_code = s1_keycode; m_shift = s1_shift; m_a1 = 1;
        end else if (s0_valid) begin
          m_code = s0_keycode; m_shift = s0_shift; m_a0 = 1;
        end else begin
          grep = 1; m_code = rep_code; m_shift = rep_shift;
        end
      end
`ifdef KBD_TYPEMATIC_EN
      if (g0 && s0_valid) begin
        rep_armed = 1; rep_cnt = DELAY - 1; rep_code = s0_keycode; rep_shift = s0_shift; rep_pend = 0;
      end else if (!s0_held || keyboard_block) begin
        rep_armed = 0; rep_pend = 0;
      end else if (rep_armed) begin
        if (rep_cnt == 0) begin
          rep_pend = 1; rep_cnt = RATE - 1;
        end else begin
          rep_cnt--;
          if (grep) rep_pend = 0;
        end
      end
`endif
    end
  end

  always @(negedge clk)
    check("cycle", {17'd0, keypress, s0_ack, s1_ack, last_src, keycode, shift_state},
                   {17'd0, m_kp, m_a0, m_a1, m_last, m_code, m_shift});

  // Each step lands just after a rising edge; sources drop valid the cycle after their ack.
  task automatic step();
    @(posedge clk); #2;
    if (was_a0) s0_valid = 1'b0;
    if (was_a1) s1_valid = 1'b0;
  endtask

  task automatic wait_kp(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!keypress && n < limit);
    if (!keypress) n = -1;
  endtask

  task automatic count_kp(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      @(negedge clk);
      if (keypress) cnt++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; fifo_full = 1'b0; keyboard_block = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  int n, cnt;

  initial begin
    do_reset();
    check("reset_keypress", {31'd0, keypress}, 32'd0);
    check("reset_last_src", {31'd0, last_src}, 32'd0);

    // Single src0 event: strobe in the cycle after the sampling edge.
    s0_valid = 1'b1; s0_keycode = 7'h2A; s0_shift = 4'h1;
    wait_kp(20, n);
    check("t1_latency", n, 2);
    check("t1_ack0", {31'd0, s0_ack}, 32'd1);
    check("t1_keycode", {25'd0, keycode}, 32'h2A);
    check("t1_shift", {28'd0, shift_state}, 32'h1);
    check("t1_last_src", {31'd0, last_src}, 32'd0);
    step();

    // Both sources from reset: src0 first, then alternation every GAP+1 cycles.
    do_reset();
    s0_valid = 1'b1; s0_keycode = 7'h01; s0_shift = 4'h0;
    s1_valid = 1'b1; s1_keycode = 7'h02; s1_shift = 4'h3;
    wait_kp(20, n);
    check("t2_first", {n[30:0], last_src}, {31'd2, 1'b0});
    step();
    wait_kp(20, n);
    check("t2_second_gap", n, GAP + 1);
    check("t2_second_src", {30'd0, s1_ack, last_src}, 32'd3);
    step();
    s0_valid = 1'b1; s0_keycode = 7'h11;
    s1_valid = 1'b1; s1_keycode = 7'h22;
    wait_kp(20, n);
    check("t2_third", {n[30:0], last_src}, {31'd5, 1'b0});
    step();
    wait_kp(20, n);
    check("t2_fourth", {n[23:0], 1'b0, keycode}, {24'd5, 1'b0, 7'h22});
    step();

    // FIFO full holds off src1 indefinitely; release gives the strobe one cycle later.
    repeat (6) step();
    fifo_full = 1'b1; s1_valid = 1'b1; s1_keycode = 7'h5A; s1_shift = 4'h2;
    count_kp(20, cnt);
    check("t3_full_silent", cnt, 0);
    step();
    fifo_full = 1'b0;
    wait_kp(20, n);
    check("t3_release", {n[30:0], s1_ack}, {31'd2, 1'b1});
    step();

    // Block stalls src0 without dropping it; src1 still flows.
    repeat (4) step();
    keyboard_block = 1'b1;
    s0_valid = 1'b1; s0_keycode = 7'h3C; s0_shift = 4'h2;
    s1_valid = 1'b1; s1_keycode = 7'h44; s1_shift = 4'h0;
    wait_kp(20, n);
    check("t4_src1_only", {n[29:0], s0_ack, s1_ack}, {30'd2, 2'b01});
    count_kp(6, cnt);
    check("t4_blocked_silent", cnt, 0);
    step();
    keyboard_block = 1'b0;
    wait_kp(20, n);
    check("t4_src0_after", {n[29:0], s0_ack, s1_ack}, {30'd2, 2'b10});
    check("t4_src0_data", {21'd0, keycode, shift_state}, {21'd0, 7'h3C, 4'h2});
    step();

    // Reset inside ISSUE kills the strobe immediately; nothing follows without a new request.
    repeat (4) step();
    s0_valid = 1'b1; s0_keycode = 7'h33;
    wait_kp(20, n);
    check("t5_issue_seen", n, 2);
    #1 reset_n = 1'b0;
    #1 check("t5_strobes_low", {30'd0, keypress, s0_ack}, 32'd0);
    s0_valid = 1'b0;
    step(); step();
    reset_n = 1'b1;
    count_kp(8, cnt);
    check("t5_no_event", cnt, 0);

`ifdef KBD_TYPEMATIC_EN
    // Typematic: first repeat DELAY+1 cycles after the original strobe, then max(RATE, GAP+1).
    repeat (2) step();
    s0_held = 1'b1; s0_valid = 1'b1; s0_keycode = 7'h15; s0_shift = 4'h0;
    wait_kp(20, n);
    check("t6_orig", n, 2);
    step();
    wait_kp(40, n);
    check("t6_first_rep", n, 11);
    check("t6_rep_data", {23'd0, s0_ack, keycode, 1'b0}, {23'd0, 1'b0, 7'h15, 1'b0});
    wait_kp(40, n);
    check("t6_second_rep", n, (RATE > GAP + 1) ? RATE : GAP + 1);
    step();
    s0_held = 1'b0;
    count_kp(30, cnt);
    check("t6_stopped", cnt, 0);
`endif

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      step();
      if (!s0_valid && $urandom_range(0, 3) == 0) begin
        s0_valid = 1'b1; s0_keycode = 7'($urandom); s0_shift = 4'($urandom);
      end
      if (!s1_valid && $urandom_range(0, 3) == 0) begin
        s1_valid = 1'b1; s1_keycode = 7'($urandom); s1_shift = 4'($urandom);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) keyboard_block = ~keyboard_block;
      if ($urandom_range(0, 31) == 0) s0_held = ~s0_held;
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
        step();
        reset_n = 1'b1;
      end
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
